// File: rtl/ps2_line_assembler_pkg.sv
// rtl/ps2_line_assembler_pkg.sv - shared scan-code constants and FSM encoding for the PS/2 line assembler
package ps2_line_assembler_pkg;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_SPACE = 8'h29;

    localparam logic [7:0] ASCII_BLANK = 8'h20;

    typedef enum logic [1:0] {
        S_NORMAL    = 2'd0,
        S_BREAK     = 2'd1,
        S_EXT       = 2'd2,
        S_EXT_BREAK = 2'd3
    } ps2_state_t;

endpackage

// File: rtl/ps2_scancode_to_ascii.sv
// rtl/ps2_scancode_to_ascii.sv - combinational set-2 make code to ASCII translation
module ps2_scancode_to_ascii
    import ps2_line_assembler_pkg::*;
(
    input  logic [7:0] scan_code,
    output logic [7:0] ascii,
    output logic       is_printable,
    output logic       is_enter,
    output logic       is_backspace
);

    always_comb begin
        ascii        = ASCII_BLANK;
        is_printable = 1'b1;
        unique case (scan_code)
            8'h1C: ascii = "A";
            8'h32: ascii = "B";
            8'h21: ascii = "C";
            8'h23: ascii = "D";
            8'h24: ascii = "E";
            8'h2B: ascii = "F";
            8'h34: ascii = "G";
            8'h33: ascii = "H";
            8'h43: ascii = "I";
            8'h3B: ascii = "J";
            8'h42: ascii = "K";
            8'h4B: ascii = "L";
            8'h3A: ascii = "M";
            8'h31: ascii = "N";
            8'h44: ascii = "O";
            8'h4D: ascii = "P";
            8'h15: ascii = "Q";
            8'h2D: ascii = "R";
            8'h1B: ascii = "S";
            8'h2C: ascii = "T";
            8'h3C: ascii = "U";
            8'h2A: ascii = "V";
            8'h1D: ascii = "W";
            8'h22: ascii = "X";
            8'h35: ascii = "Y";
            8'h1A: ascii = "Z";
            8'h45: ascii = "0";
            8'h16: ascii = "1";
            8'h1E: ascii = "2";
            8'h26: ascii = "3";
            8'h25: ascii = "4";
            8'h2E: ascii = "5";
            8'h36: ascii = "6";
            8'h3D: ascii = "7";
            8'h3E: ascii = "8";
            8'h46: ascii = "9";
            SC_SPACE: ascii = ASCII_BLANK;
            default: is_printable = 1'b0;
        endcase
    end

    assign is_enter     = (scan_code == SC_ENTER);
    assign is_backspace = (scan_code == SC_BKSP);

endmodule

// File: rtl/ps2_line_assembler.sv
// rtl/ps2_line_assembler.sv - filters PS/2 scan codes, edits a line buffer and commits it on Enter
module ps2_line_assembler
    import ps2_line_assembler_pkg::*;
#(
    parameter int         MAX_CHARS  = 32,
    parameter logic [7:0] BLANK_CHAR = ASCII_BLANK
) (
    input  logic                             clock,
    input  logic                             resetn,
    input  logic [7:0]                       ps2_key_data,
    input  logic                             ps2_key_pressed,
    output logic [8*MAX_CHARS-1:0]           input_line,
    output logic                             line_ready,
    output logic [8*MAX_CHARS-1:0]           edit_line,
    output logic [$clog2(MAX_CHARS+1)-1:0]   char_count
);

    localparam int CNT_W = $clog2(MAX_CHARS + 1);
    localparam int IDX_W = $clog2(MAX_CHARS);

    ps2_state_t state_q, state_d;

    logic [7:0] line_buf [MAX_CHARS];
    logic [7:0] ascii;
    logic       is_printable;
    logic       is_enter;
    logic       is_backspace;
    logic       do_print, do_bksp, do_enter;
    logic       print_ok, bksp_ok, commit;
    logic [IDX_W-1:0] wr_idx, bk_idx;

    ps2_scancode_to_ascii u_map (
        .scan_code    (ps2_key_data),
        .ascii        (ascii),
        .is_printable (is_printable),
        .is_enter     (is_enter),
        .is_backspace (is_backspace)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_NORMAL;
        end else begin
            state_q <= state_d;
        end
    end

    // Break and extended-break states swallow exactly one following byte, whatever it is.
    always_comb begin
        state_d  = state_q;
        do_print = 1'b0;
        do_bksp  = 1'b0;
        do_enter = 1'b0;
        if (ps2_key_pressed) begin
            unique case (state_q)
                S_NORMAL: begin
                    if (ps2_key_data == SC_BREAK) begin
                        state_d = S_BREAK;
                    end else if (ps2_key_data == SC_EXT) begin
                        state_d = S_EXT;
                    end else begin
                        do_print = is_printable;
                        do_bksp  = is_backspace;
                        do_enter = is_enter;
                    end
                end
                S_BREAK: state_d = S_NORMAL;
                S_EXT: begin
                    if (ps2_key_data == SC_BREAK) begin
                        state_d = S_EXT_BREAK;
                    end else begin
                        state_d  = S_NORMAL;
                        do_enter = (ps2_key_data == SC_ENTER);
                    end
                end
                S_EXT_BREAK: state_d = S_NORMAL;
                default: state_d = S_NORMAL;
            endcase
        end
    end

    assign print_ok = do_print && (char_count < CNT_W'(MAX_CHARS));
    assign bksp_ok  = do_bksp && (char_count != '0);
    assign commit   = do_enter && (char_count != '0);
    assign wr_idx   = IDX_W'(char_count);
    assign bk_idx   = IDX_W'(char_count - CNT_W'(1));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            input_line <= {MAX_CHARS{BLANK_CHAR}};
            line_ready <= 1'b0;
            char_count <= '0;
            for (int k = 0; k < MAX_CHARS; k++) begin
                line_buf[k] <= BLANK_CHAR;
            end
        end else begin
            line_ready <= 1'b0;
            if (commit) begin
                input_line <= edit_line;
                line_ready <= 1'b1;
                char_count <= '0;
                for (int k = 0; k < MAX_CHARS; k++) begin
                    line_buf[k] <= BLANK_CHAR;
                end
            end else if (print_ok) begin
                line_buf[wr_idx] <= ascii;
                char_count       <= char_count + CNT_W'(1);
            end else if (bksp_ok) begin
                line_buf[bk_idx] <= BLANK_CHAR;
                char_count       <= char_count - CNT_W'(1);
            end
        end
    end

    // Char 0 sits in the most significant byte so the line reads left to right.
    always_comb begin
        edit_line = '0;
        for (int k = 0; k < MAX_CHARS; k++) begin
            edit_line[8*(MAX_CHARS-1-k) +: 8] = line_buf[k];
        end
    end

endmodule

// File: tb/tb_ps2_line_assembler.sv
// tb/tb_ps2_line_assembler.sv - scoreboard bench for ps2_line_assembler
module tb_ps2_line_assembler;

    localparam logic [255:0] BLANK_LINE = {32{8'h20}};

    logic         clock = 1'b0;
    logic         resetn = 1'b0;
    logic [7:0]   ps2_key_data = 8'h00;
    logic         ps2_key_pressed = 1'b0;
    logic [255:0] input_line;
    logic         line_ready;
    logic [255:0] edit_line;
    logic [5:0]   char_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [255:0] exp_q[$];
    logic [255:0] exp_input = BLANK_LINE;
    logic [255:0] m_edit = BLANK_LINE;
    int           m_cnt = 0;

    ps2_line_assembler dut (
        .clock           (clock),
        .resetn          (resetn),
        .ps2_key_data    (ps2_key_data),
        .ps2_key_pressed (ps2_key_pressed),
        .input_line      (input_line),
        .line_ready      (line_ready),
        .edit_line       (edit_line),
        .char_count      (char_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!resetn) begin
            exp_input = BLANK_LINE;
        end else begin
            if (line_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_line_ready", 256'(line_ready), 256'(0));
                end else begin
                    exp_input = exp_q.pop_front();
                end
            end
            check("input_line", input_line, exp_input);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clock); #1;
        ps2_key_data    = b;
        ps2_key_pressed = 1'b1;
        @(posedge clock); #1;
        ps2_key_pressed = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic check_edit(input string tag);
        check({tag, "_count"}, 256'(char_count), 256'(m_cnt));
        check({tag, "_edit"}, edit_line, m_edit);
    endtask

    task automatic press_char(input logic [7:0] code, input logic [7:0] ch);
        send_byte(code);
        if (m_cnt < 32) begin
            m_edit[255-8*m_cnt -: 8] = ch;
            m_cnt++;
        end
        send_byte(8'hF0);
        send_byte(code);
    endtask

    task automatic press_bksp();
        send_byte(8'h66);
        if (m_cnt > 0) begin
            m_cnt--;
            m_edit[255-8*m_cnt -: 8] = 8'h20;
        end
        send_byte(8'hF0);
        send_byte(8'h66);
    endtask

    task automatic press_enter(input bit ext);
        if (m_cnt > 0) begin
            exp_q.push_back(m_edit);
            m_edit = BLANK_LINE;
            m_cnt  = 0;
        end
        if (ext) send_byte(8'hE0);
        send_byte(8'h5A);
        if (ext) send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h5A);
    endtask

    task automatic type_set();
        press_char(8'h1B, "S");
        press_char(8'h24, "E");
        press_char(8'h2C, "T");
    endtask

    initial begin
        logic [7:0] t1_codes [11] = '{8'h1B, 8'h24, 8'h2C, 8'h29, 8'h2A, 8'h29,
                                      8'h45, 8'h45, 8'h45, 8'h36, 8'h45};
        logic [7:0] t1_chars [11] = '{"S", "E", "T", " ", "V", " ", "0", "0", "0", "6", "0"};

        repeat (3) @(posedge clock);
        #1;
        check("reset_input_line", input_line, BLANK_LINE);
        check("reset_edit_line", edit_line, BLANK_LINE);
        check("reset_count", 256'(char_count), 256'(0));
        check("reset_ready", 256'(line_ready), 256'(0));
        resetn = 1'b1;

        // 1: SET V 00060
        for (int i = 0; i < 11; i++) press_char(t1_codes[i], t1_chars[i]);
        check_edit("t1_typed");
        press_enter(1'b0);
        check("t1_commit", input_line, {"SET V 00060", {21{8'h20}}});
        check_edit("t1_after");

        // 2: backspace editing
        press_bksp();
        check_edit("t2_bksp_empty");
        type_set();
        press_char(8'h29, " ");
        press_char(8'h1C, "A");
        press_char(8'h29, " ");
        press_char(8'h45, "0");
        press_char(8'h22, "X");
        press_bksp();
        check_edit("t2_bksp");
        press_char(8'h3D, "7");
        press_char(8'h45, "0");
        press_enter(1'b0);
        check("t2_commit", input_line, {"SET A 070", {23{8'h20}}});

        // 3: saturation at 32 characters
        for (int i = 0; i < 33; i++) press_char(8'h16, "1");
        check_edit("t3_full");
        check("t3_all_ones", edit_line, {32{8'h31}});
        press_enter(1'b0);
        check("t3_commit", input_line, {32{8'h31}});

        // 4: empty Enter, keypad Enter, extended non-enter keys
        press_enter(1'b0);
        press_enter(1'b1);
        check("t4_keep", input_line, {32{8'h31}});
        type_set();
        send_byte(8'hE0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        check_edit("t4_arrow");
        press_enter(1'b1);
        check("t4_ext_commit", input_line, {"SET", {29{8'h20}}});

        // 6: edit after commit leaves input_line alone
        press_char(8'h1C, "A");
        check_edit("t6_edit");
        check("t6_edit_val", edit_line, {"A", {31{8'h20}}});
        repeat (5) @(posedge clock);
        #1;
        check("t6_hold", input_line, {"SET", {29{8'h20}}});
        press_bksp();

        // 5: break of R, then reset mid-break
        type_set();
        send_byte(8'hF0);
        send_byte(8'h2D);
        check_edit("t5_break");
        send_byte(8'hF0);
        @(posedge clock); #3;
        resetn = 1'b0;
        #1;
        check("t5_rst_input", input_line, BLANK_LINE);
        check("t5_rst_edit", edit_line, BLANK_LINE);
        check("t5_rst_count", 256'(char_count), 256'(0));
        check("t5_rst_ready", 256'(line_ready), 256'(0));
        m_edit = BLANK_LINE;
        m_cnt  = 0;
        exp_q.delete();
        @(posedge clock); #1;
        resetn = 1'b1;
        press_char(8'h1B, "S");
        check_edit("t5_fresh");
        press_enter(1'b0);
        check("t5_commit", input_line, {"S", {31{8'h20}}});

        repeat (4) @(posedge clock);
        #1;
        check("pending_commits", 256'(exp_q.size()), 256'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ps2_line_assembler.md
Name: ps2_line_assembler

Overview:
- Sits between the PS/2 keyboard receiver and the command interpreter.
- Consumes set-2 scan-code bytes and filters out break and extended prefixes.
- Maps make codes to ASCII and edits a 32-character line buffer, supporting typing and backspace.
- On Enter, commits the line as a left-justified 256-bit ASCII word and pulses line_ready for the interpreter.

Parameters:
- MAX_CHARS, 32: line length in characters; input_line width = 8*MAX_CHARS.
- BLANK_CHAR, 8'h20: fill byte for empty character positions.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- ps2_key_data  in  8  received scan-code byte; valid only when ps2_key_pressed = 1.
- ps2_key_pressed  in  1  one-cycle strobe: a new byte is on ps2_key_data.
- input_line  out  256  last committed line; char 0 at [255:248], char k at [255-8k : 248-8k].
- line_ready  out  1  one-cycle pulse marking a new commit.
- edit_line  out  256  live edit buffer in the same layout; for display.
- char_count  out  6  characters currently in the edit buffer, 0..32.

Behaviour:
- Reset (async assert, sync release):
  - input_line and edit_line = all BLANK_CHAR.
  - char_count = 0, line_ready = 0, FSM = S_NORMAL.
- Input bytes are processed only on cycles where ps2_key_pressed = 1. Bytes arrive at least 2 cycles apart.
- FSM:
  - S_NORMAL: F0 -> S_BREAK; E0 -> S_EXT; any other byte is a make code -> action, stay in S_NORMAL.
  - S_BREAK: any byte -> S_NORMAL, no action (key release).
  - S_EXT: F0 -> S_EXT_BREAK; 5A -> Enter action, then S_NORMAL; any other byte -> S_NORMAL, no action.
  - S_EXT_BREAK: any byte -> S_NORMAL, no action.
  - Repeated F0 or E0 bytes in S_BREAK or S_EXT_BREAK are consumed as that state's one byte.
- Make-code actions (ASCII from the sub-module):
  - Printable (A-Z uppercase, 0-9, space):
    - If char_count < 32: write the char at position char_count, then char_count + 1.
    - If char_count = 32: drop the char, no change.
  - Backspace (66):
    - If char_count > 0: char_count - 1, and the vacated position is set to BLANK_CHAR.
    - If char_count = 0: ignored.
  - Enter (5A):
    - If char_count > 0: on the same edge, input_line <= edit_line, edit_line <= all BLANK, char_count <= 0, line_ready <= 1 for exactly one cycle.
    - If char_count = 0: no commit, no pulse.
  - Unmapped codes: ignored.
- Latency: outputs update on the clock edge that samples the strobe. line_ready is high during the cycle after the strobe.
- Stability: input_line holds its value until the next commit. It is guaranteed stable for at least 2 cycles after line_ready, because the interpreter latches derived values one cycle later.
- Auto-repeat make codes (no break byte in between) are each acted on.
- Reset asserted mid-sequence (e.g. in S_BREAK) returns the FSM to S_NORMAL; the next byte is treated as fresh.

Decomposition:
- Shared package holds:
  - Scan-code constants: SC_BREAK = F0, SC_EXT = E0, SC_ENTER = 5A, SC_BKSP = 66, SC_SPACE = 29.
  - FSM state encoding.
  - ASCII_BLANK.
- One combinational sub-module, ps2_scancode_to_ascii: 8-bit scan code in; ASCII byte plus is_printable, is_enter and is_backspace flags out.
- FSM, buffer and commit logic stay in ps2_line_assembler.

Test Plan:
1. Type "SET V 00060" as make/F0/make pairs (1B 24 2C 29 2A 29 45 45 45 36 45), then 5A F0 5A:
   - line_ready pulses once.
   - input_line[255:168] = 53 45 54 20 56 20 30 30 30 36 30; remaining bytes are 20.
   - char_count returns to 0.
2. Type "SET A 0X", then backspace (66), then "70", then Enter:
   - Committed line = "SET A 070".
   - Backspace at char_count = 0 leaves the buffer unchanged.
3. Type 33 digit '1' keys:
   - char_count saturates at 32; all 32 bytes are 31; the 33rd char is dropped.
   - Enter commits all 32 bytes.
4. Enter with an empty buffer:
   - No line_ready; input_line keeps the previous commit.
   - E0 5A after typing "SET" commits "SET".
   - E0 75 (arrow) and E0 F0 75 cause no edits.
5. Type "SET", then inject F0 followed by 2D (break of R):
   - No 'R' is added; char_count = 3.
   - Assert resetn = 0 asynchronously mid-cycle: all outputs reach reset values immediately.
6. After a commit, type a new character:
   - input_line is unchanged for all following cycles until the next Enter.
   - edit_line reflects the new character.
